// File: rtl/engine_stride_lane_scheduler_pkg.sv
// rtl/engine_stride_lane_scheduler_pkg.sv - shared engine types for the stride lane scheduler
package engine_stride_lane_scheduler_pkg;

    localparam int M_AXI_MEMORY_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [7:0]  id_cu;
        logic [15:0] id_bundle;
        logic [7:0]  cmd;
    } MemoryPacketMeta;

    typedef struct packed {
        logic                               valid;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_start;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_end;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] stride;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] granularity;
        logic                               increment;
        logic                               decrement;
        MemoryPacketMeta                    meta;
    } StrideIndexConfiguration;

    typedef enum logic [2:0] {
        RESET = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4,
        PAUSE = 3'd5,
        DONE  = 3'd6
    } engine_stride_lane_sched_state;

endpackage

// File: rtl/engine_stride_lane_scheduler.sv
// rtl/engine_stride_lane_scheduler.sv - stride index sequencer with strict round-robin lane batches
module engine_stride_lane_scheduler
    import engine_stride_lane_scheduler_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int INDEX_WIDTH = M_AXI_MEMORY_ADDR_WIDTH
) (
    input  logic                                   ap_clk,
    input  logic                                   areset,
    input  logic [$bits(StrideIndexConfiguration)-1:0] config_in,
    output logic                                   config_ready_out,
    input  logic                                   start_in,
    input  logic                                   pause_in,
    input  logic [NUM_LANES-1:0]                   lane_ready_in,
    output logic [NUM_LANES-1:0]                   lane_valid_out,
    output logic [INDEX_WIDTH-1:0]                 index_out,
    output logic [$bits(MemoryPacketMeta)-1:0]     meta_out,
    output logic                                   done_out
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int W  = INDEX_WIDTH;

    engine_stride_lane_sched_state state_q, state_d;
    logic [W-1:0]         start_q, start_d, end_q, end_d, stride_q, stride_d;
    logic [W-1:0]         gran_q, gran_d, batch_q, batch_d, idx_q, idx_d;
    logic [W-1:0]         index_q, index_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic                 inc_q, inc_d, dec_q, dec_d, exh_q, exh_d;
    logic [NUM_LANES-1:0] valid_q, valid_d;
    MemoryPacketMeta      meta_q, meta_d;

    StrideIndexConfiguration cfg;
    logic [W:0]           sum, diff;
    logic                 xfer, can_emit, issue_ok, load, drained;

    always_comb begin
        cfg       = StrideIndexConfiguration'(config_in);
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        stride_d  = stride_q;
        gran_d    = gran_q;
        batch_d   = batch_q;
        idx_d     = idx_q;
        index_d   = index_q;
        lane_d    = lane_q;
        inc_d     = inc_q;
        dec_d     = dec_q;
        exh_d     = exh_q;
        valid_d   = valid_q;
        meta_d    = meta_q;

        sum  = {1'b0, idx_q} + {1'b0, stride_q};
        diff = {1'b0, idx_q} - {1'b0, stride_q};

        // exh_q records a carry/borrow from the previous step, so idx_q is no longer meaningful
        can_emit = 1'b0;
        if (!exh_q) begin
            if (inc_q && !dec_q)      can_emit = (idx_q < end_q);
            else if (dec_q && !inc_q) can_emit = (idx_q > end_q);
        end

        xfer     = |(valid_q & lane_ready_in);
        drained  = (valid_q == '0) || xfer;
        issue_ok = !pause_in && ((state_q == BUSY) || (state_q == PAUSE) ||
                                 ((state_q == START) && start_in));
        load     = issue_ok && can_emit && drained;

        if (xfer) begin
            valid_d = '0;
            if (batch_q + 1'b1 == gran_q) begin
                batch_d = '0;
                lane_d  = (lane_q == LW'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
            end else begin
                batch_d = batch_q + 1'b1;
            end
        end

        if (load) begin
            index_d = idx_q;
            valid_d = NUM_LANES'(1) << lane_d;
            idx_d   = inc_q ? sum[W-1:0] : diff[W-1:0];
            exh_d   = inc_q ? sum[W] : diff[W];
        end

        case (state_q)
            RESET: state_d = IDLE;
            IDLE: begin
                if (cfg.valid) begin
                    state_d  = SETUP;
                    start_d  = W'(cfg.index_start);
                    end_d    = W'(cfg.index_end);
                    stride_d = W'(cfg.stride);
                    gran_d   = W'(cfg.granularity);
                    inc_d    = cfg.increment;
                    dec_d    = cfg.decrement;
                    meta_d   = cfg.meta;
                end
            end
            SETUP: begin
                state_d = START;
                idx_d   = start_q;
                lane_d  = '0;
                batch_d = '0;
                exh_d   = 1'b0;
                gran_d  = (gran_q == '0) ? W'(1) : gran_q;
            end
            START: if (start_in) state_d = BUSY;
            BUSY: begin
                if (pause_in)                 state_d = PAUSE;
                else if (!can_emit && drained) state_d = DONE;
            end
            PAUSE: if (!pause_in) state_d = BUSY;
            DONE:  if (!start_in) state_d = IDLE;
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q  <= RESET;
            start_q  <= '0;
            end_q    <= '0;
            stride_q <= '0;
            gran_q   <= '0;
            batch_q  <= '0;
            idx_q    <= '0;
            index_q  <= '0;
            lane_q   <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            exh_q    <= 1'b0;
            valid_q  <= '0;
            meta_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            end_q    <= end_d;
            stride_q <= stride_d;
            gran_q   <= gran_d;
            batch_q  <= batch_d;
            idx_q    <= idx_d;
            index_q  <= index_d;
            lane_q   <= lane_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            exh_q    <= exh_d;
            valid_q  <= valid_d;
            meta_q   <= meta_d;
        end
    end

    assign config_ready_out = (state_q == IDLE);
    assign done_out         = (state_q == DONE);
    assign lane_valid_out   = valid_q;
    assign index_out        = index_q;
    assign meta_out         = meta_q;

endmodule
